// File: rtl/morse_rx_decoder.sv
// Morse line receiver: times marks/spaces, decodes A-Z to 5-bit codes.
// Optional word-gap space code (0) enabled by MORSE_RX_WORDGAP_EN.
module morse_rx_decoder #(
    parameter int TIME_UNIT = 250000,
    parameter int CNT_W     = 24
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       morse_in,
    input  logic       char_ready,
    output logic [4:0] char_out,
    output logic       char_valid,
    output logic       busy,
    output logic       overflow
);

    localparam logic [CNT_W-1:0] TH2 = CNT_W'(2 * TIME_UNIT);
    localparam logic [CNT_W-1:0] TH5 = CNT_W'(5 * TIME_UNIT);

    typedef enum logic [1:0] {
        IDLE,
        MARK,
        SPACE_OPEN,
        SPACE_SHUT
    } state_t;

    state_t            state_q, state_d;
    logic              s1, s, s_d;
    logic              rise, fall;
    logic [CNT_W-1:0]  cnt;
    logic [3:0]        pat_q, pat_d;
    logic [2:0]        len_q, len_d;
    logic              err_q, err_d;
    logic              new_letter;
    logic              emit;
    logic [4:0]        emit_code;
    logic [4:0]        letter_code;

    function automatic logic [4:0] decode(input logic [2:0] len,
                                          input logic [3:0] pat);
        logic [4:0] c;
        case ({len, pat})
            {3'd1, 4'b0000}: c = 5'd5;
            {3'd1, 4'b0001}: c = 5'd20;
            {3'd2, 4'b0000}: c = 5'd9;
            {3'd2, 4'b0001}: c = 5'd1;
            {3'd2, 4'b0010}: c = 5'd14;
            {3'd2, 4'b0011}: c = 5'd13;
            {3'd3, 4'b0000}: c = 5'd19;
            {3'd3, 4'b0001}: c = 5'd21;
            {3'd3, 4'b0010}: c = 5'd18;
            {3'd3, 4'b0011}: c = 5'd23;
            {3'd3, 4'b0100}: c = 5'd4;
            {3'd3, 4'b0101}: c = 5'd11;
            {3'd3, 4'b0110}: c = 5'd7;
            {3'd3, 4'b0111}: c = 5'd15;
            {3'd4, 4'b0000}: c = 5'd8;
            {3'd4, 4'b0001}: c = 5'd22;
            {3'd4, 4'b0010}: c = 5'd6;
            {3'd4, 4'b0100}: c = 5'd12;
            {3'd4, 4'b0110}: c = 5'd16;
            {3'd4, 4'b0111}: c = 5'd10;
            {3'd4, 4'b1000}: c = 5'd2;
            {3'd4, 4'b1001}: c = 5'd24;
            {3'd4, 4'b1010}: c = 5'd3;
            {3'd4, 4'b1011}: c = 5'd25;
            {3'd4, 4'b1100}: c = 5'd26;
            {3'd4, 4'b1101}: c = 5'd17;
            default:         c = 5'd31;
        endcase
        return c;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s   <= 1'b0;
            s_d <= 1'b0;
        end else begin
            s1  <= morse_in;
            s   <= s1;
            s_d <= s;
        end
    end

    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // Counter holds the length of the current level, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (s != s_d) begin
            cnt <= CNT_W'(1);
        end else if (cnt != '1) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign letter_code = err_q ? 5'd31 : decode(len_q, pat_q);

    always_comb begin
        state_d    = state_q;
        pat_d      = pat_q;
        len_d      = len_q;
        err_d      = err_q;
        new_letter = 1'b0;
        emit       = 1'b0;
        emit_code  = letter_code;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d    = MARK;
                    new_letter = 1'b1;
                end
            end
            MARK: begin
                if (fall) begin
                    state_d = SPACE_OPEN;
                    if (len_q == 3'd4) begin
                        err_d = 1'b1;
                    end else begin
                        pat_d = {pat_q[2:0], (cnt >= TH2)};
                        len_d = len_q + 3'd1;
                    end
                end
            end
            SPACE_OPEN: begin
                if (cnt >= TH2) begin
                    emit       = 1'b1;
                    state_d    = rise ? MARK : SPACE_SHUT;
                    new_letter = rise;
                end else if (rise) begin
                    state_d = MARK;
                end
            end
            SPACE_SHUT: begin
                if (cnt >= TH5) begin
`ifdef MORSE_RX_WORDGAP_EN
                    emit      = 1'b1;
                    emit_code = 5'd0;
`endif
                    state_d    = rise ? MARK : IDLE;
                    new_letter = rise;
                end else if (rise) begin
                    state_d    = MARK;
                    new_letter = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (new_letter) begin
            pat_d = '0;
            len_d = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            err_q   <= err_d;
        end
    end

    // A handshake in the emit cycle frees the slot for the new code.
    always_ff @(posedge clk) begin
        if (rst) begin
            char_out   <= '0;
            char_valid <= 1'b0;
            overflow   <= 1'b0;
        end else if (emit) begin
            if (!char_valid || char_ready) begin
                char_out   <= emit_code;
                char_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (char_valid && char_ready) begin
            char_valid <= 1'b0;
        end
    end

    assign busy = (state_q != IDLE);

endmodule
